// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions: field widths, group/operator codes,
// low-bit format tags, encoder FSM states and the decoded-field payload.
package instr_encoder_pkg;

    localparam int unsigned GROUP_W = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned VAL_W   = 8;
    localparam int unsigned OFF_W   = 9;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BYTE_W  = 8;

    // Instruction group codes (same numbering the decoder uses)
    localparam logic [GROUP_W-1:0] GROUP_MATH_CONSTANT = 4'd0;
    localparam logic [GROUP_W-1:0] GROUP_BRANCH_JUMPS  = 4'd1;
    localparam logic [GROUP_W-1:0] GROUP_MATH_REG      = 4'd2;
    localparam logic [GROUP_W-1:0] GROUP_MATH_EREG     = 4'd3;
    localparam logic [GROUP_W-1:0] GROUP_SINGLE_REG    = 4'd4;
    localparam logic [GROUP_W-1:0] GROUP_STACK         = 4'd5;
    localparam logic [GROUP_W-1:0] GROUP_REG_MEMORY    = 4'd6;
    localparam logic [GROUP_W-1:0] GROUP_EXTENDED      = 4'd7;
    localparam logic [GROUP_W-1:0] GROUP_OTHERS        = 4'd8;
    localparam logic [GROUP_W-1:0] GROUP_RETURN        = 4'd9;

    // Low-bit format tags shared with the decoder
    localparam logic [2:0] TAG_BRANCH  = 3'b011;
    localparam logic [3:0] TAG_REG     = 4'b0111;
    localparam logic [4:0] TAG_EREG    = 5'b01111;
    localparam logic [5:0] TAG_SINGLE  = 6'b011111;
    localparam logic [6:0] TAG_REGMEM  = 7'b0111111;
    localparam logic [7:0] TAG_EXT     = 8'h7F;
    localparam logic [7:0] TAG_OTHERS  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [GROUP_W-1:0] group;
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rg1;
        logic [REG_W-1:0]   rg2;
        logic [VAL_W-1:0]   val;
        logic [OFF_W-1:0]   offset;
    } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: decoded fields -> 16-bit instruction word + legality.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  instr_fields_t       i_fields,
    output logic [WORD_W-1:0]   o_word,
    output logic                o_legal
);

    // Select the word layout by group and flag field sets the decoder cannot represent
    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_fields.group)
            GROUP_MATH_CONSTANT: begin
                o_word  = {i_fields.val, i_fields.rg1, i_fields.op};
                o_legal = (i_fields.op[0] == 1'b0) || (i_fields.op[1:0] == 2'b01);
            end
            GROUP_BRANCH_JUMPS: begin
                o_word = {i_fields.offset, i_fields.op, TAG_BRANCH};
            end
            GROUP_MATH_REG: begin
                o_word = {i_fields.rg2, i_fields.rg1, i_fields.op, TAG_REG};
            end
            GROUP_MATH_EREG: begin
                o_word  = {3'b000, i_fields.rg2[1:0], i_fields.rg1[1:0], i_fields.op, TAG_EREG};
                o_legal = (i_fields.rg1[3:2] == 2'b00) && (i_fields.rg2[3:2] == 2'b00);
            end
            GROUP_SINGLE_REG, GROUP_STACK: begin
                o_word = {2'b00, i_fields.rg1, i_fields.op, TAG_SINGLE};
            end
            GROUP_REG_MEMORY: begin
                o_word  = {i_fields.rg2[1:0], i_fields.rg1, i_fields.op[2:0], TAG_REGMEM};
                o_legal = (i_fields.op[3] == 1'b0) && (i_fields.rg2[3:2] == 2'b00);
            end
            GROUP_EXTENDED: begin
                o_word = {4'h0, i_fields.op, TAG_EXT};
            end
            GROUP_OTHERS, GROUP_RETURN: begin
                o_word = {4'h0, i_fields.op, TAG_OTHERS};
            end
            default: begin
                o_word  = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded fields, packs them and writes the word
// little-endian into program memory at an auto-incrementing byte pointer.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [GROUP_W-1:0]  group,
    input  logic [OP_W-1:0]     operator,
    input  logic [REG_W-1:0]    rg1,
    input  logic [REG_W-1:0]    rg2,
    input  logic [VAL_W-1:0]    val,
    input  logic [OFF_W-1:0]    offset,
    input  logic                addr_load,
    input  logic [ADDR_W-1:0]   addr_in,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BYTE_W-1:0]   mem_data,
    output logic                mem_wr,
    input  logic                mem_ack,
    output logic                err,
    output logic                busy,
    output logic [WORD_W-1:0]   last_word
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO = ADDR_W'(2);

    enc_state_e           r_state;
    logic [ADDR_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]    r_addr;
    logic [BYTE_W-1:0]    r_data;
    logic                 r_wr;
    logic                 r_err;
    logic [WORD_W-1:0]    r_last;

    instr_fields_t        w_fields;
    logic [WORD_W-1:0]    w_word;
    logic                 w_legal;

    assign w_fields = '{group: group, op: operator, rg1: rg1, rg2: rg2,
                        val: val, offset: offset};

    instr_pack u_pack (
        .i_fields (w_fields),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign in_ready  = (r_state == ST_IDLE) && !addr_load;
    assign busy      = (r_state != ST_IDLE);
    assign mem_addr  = r_addr;
    assign mem_data  = r_data;
    assign mem_wr    = r_wr;
    assign err       = r_err;
    assign last_word = r_last;

    // Accept / write-low / write-high sequencer with pointer and bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (addr_load) begin
                        r_ptr <= addr_in;
                    end else if (in_valid) begin
                        if (w_legal) begin
                            r_last  <= w_word;
                            r_addr  <= r_ptr;
                            r_data  <= w_word[7:0];
                            r_wr    <= 1'b1;
                            r_state <= ST_WR_LO;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WR_LO: begin
                    if (mem_ack) begin
                        r_addr  <= r_ptr + PTR_ONE;
                        r_data  <= r_last[15:8];
                        r_state <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    if (mem_ack) begin
                        r_ptr   <= r_ptr + PTR_TWO;
                        r_wr    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_wr    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// traffic compared every cycle against a byte-write queue model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  group;
    logic [3:0]  operator;
    logic [3:0]  rg1;
    logic [3:0]  rg2;
    logic [7:0]  val;
    logic [8:0]  offset;
    logic        addr_load;
    logic [15:0] addr_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;
    logic        mem_ack;
    logic        err;
    logic        busy;
    logic [15:0] last_word;

    int total = 0;
    int bad   = 0;
    int ack_mode = 0;   // 0: ack high, 1: ack low, 2: random

    instr_encoder #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .group(group), .operator(operator), .rg1(rg1), .rg2(rg2), .val(val),
        .offset(offset), .addr_load(addr_load), .addr_in(addr_in),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .err(err), .busy(busy), .last_word(last_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoding computed arithmetically from the field layout rules
    function automatic void model_enc(input int g, input int op, input int r1, input int r2,
                                      input int v, input int off,
                                      output logic [15:0] w, output logic lg);
        int x;
        x  = 0;
        lg = 1'b1;
        case (g)
            0: begin x = v*256 + r1*16 + op; lg = (op % 2 == 0) || (op % 4 == 1); end
            1: x = off*128 + op*8 + 3;
            2: x = r2*4096 + r1*256 + op*16 + 7;
            3: begin x = (r2 % 4)*2048 + (r1 % 4)*512 + op*32 + 15; lg = (r1 < 4) && (r2 < 4); end
            4, 5: x = r1*1024 + op*64 + 31;
            6: begin x = (r2 % 4)*16384 + r1*1024 + (op % 8)*128 + 63; lg = (op < 8) && (r2 < 4); end
            7: x = op*256 + 127;
            8, 9: x = op*256 + 255;
            default: lg = 1'b0;
        endcase
        w = 16'(x);
    endfunction

    // Model: queue of byte writes still owed to memory, next free pointer, last word
    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t         q[$];
    logic [15:0] m_ptr;
    logic [15:0] m_last;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] w;
        logic        lg;
        if (!rst_n) begin
            q.delete();
            m_ptr  = '0;
            m_last = '0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (q.size() != 0) begin
                if (mem_ack) void'(q.pop_front());
            end else if (addr_load) begin
                m_ptr = addr_in;
            end else if (in_valid) begin
                model_enc(int'(group), int'(operator), int'(rg1), int'(rg2),
                          int'(val), int'(offset), w, lg);
                if (lg) begin
                    q.push_back('{a: m_ptr, d: w[7:0]});
                    q.push_back('{a: m_ptr + 16'd1, d: w[15:8]});
                    m_ptr  = m_ptr + 16'd2;
                    m_last = w;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Compare all outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_wr", mem_wr, q.size() != 0);
            if (q.size() != 0) begin
                chk("mem_addr", mem_addr, q[0].a);
                chk("mem_data", mem_data, q[0].d);
            end
            chk("busy", busy, q.size() != 0);
            chk("in_ready", in_ready, (q.size() == 0) && !addr_load);
            chk("err", err, m_err);
            chk("last_word", last_word, m_last);
            chk("err_busy_excl", err && busy, 1'b0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = 1'b0;
            default: mem_ack = 1'($urandom % 2);
        endcase
    endtask

    task automatic load(input logic [15:0] a);
        addr_load = 1'b1;
        addr_in   = a;
        cyc();
        addr_load = 1'b0;
    endtask

    task automatic send(input logic [3:0] g, input logic [3:0] op, input logic [3:0] r1,
                        input logic [3:0] r2, input logic [7:0] v, input logic [8:0] off);
        group = g; operator = op; rg1 = r1; rg2 = r2; val = v; offset = off;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) cyc();
        chk("idle_wait", busy, 1'b0);
    endtask

    initial begin
        logic [15:0] w;
        logic        lg;

        rst_n = 1'b0; in_valid = 1'b0; group = '0; operator = '0; rg1 = '0; rg2 = '0;
        val = '0; offset = '0; addr_load = 1'b0; addr_in = '0; mem_ack = 1'b1;

        // Pin the reference encoder to hand-computed words
        model_enc(2, 3, 2, 5, 0, 0, w, lg);     chk("pin_math_reg", {lg, w}, {1'b1, 16'h5237});
        model_enc(0, 2, 1, 0, 8'hAB, 0, w, lg); chk("pin_math_const", {lg, w}, {1'b1, 16'hAB12});
        model_enc(0, 3, 1, 0, 8'hAB, 0, w, lg); chk("pin_const_ill", lg, 1'b0);
        model_enc(1, 5, 0, 0, 0, 9'h1FE, w, lg); chk("pin_branch", {lg, w}, {1'b1, 16'hFF2B});
        model_enc(7, 12, 0, 0, 0, 0, w, lg);    chk("pin_ext", {lg, w}, {1'b1, 16'h0C7F});
        model_enc(6, 3, 10, 2, 0, 0, w, lg);    chk("pin_regmem", {lg, w}, {1'b1, 16'hA9BF});

        @(posedge clk); @(posedge clk); #1;
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_data", mem_data, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_last", last_word, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cyc();

        // MATH_REG at 0x0100
        load(16'h0100);
        send(GROUP_MATH_REG, 4'd3, 4'd2, 4'd5, 8'h00, 9'h000);
        chk("mr_lo_addr", mem_addr, 16'h0100); chk("mr_lo_data", mem_data, 8'h37);
        chk("mr_lo_wr", mem_wr, 1'b1);
        cyc();
        chk("mr_hi_addr", mem_addr, 16'h0101); chk("mr_hi_data", mem_data, 8'h52);
        cyc();
        chk("mr_done", busy, 1'b0); chk("mr_last", last_word, 16'h5237);

        // MATH_CONSTANT legal then illegal
        send(GROUP_MATH_CONSTANT, 4'd2, 4'd1, 4'd0, 8'hAB, 9'h000);
        wait_idle();
        chk("mc_last", last_word, 16'hAB12);
        send(GROUP_MATH_CONSTANT, 4'd3, 4'd1, 4'd0, 8'hAB, 9'h000);
        chk("mc_err", err, 1'b1); chk("mc_err_nowr", mem_wr, 1'b0);
        cyc();
        chk("mc_err_pulse", err, 1'b0); chk("mc_err_last", last_word, 16'hAB12);
        send(GROUP_MATH_REG, 4'd0, 4'd0, 4'd0, 8'h00, 9'h000);
        chk("mc_ptr_kept", mem_addr, 16'h0104);
        wait_idle();

        send(GROUP_BRANCH_JUMPS, 4'd5, 4'd0, 4'd0, 8'h00, 9'h1FE);
        wait_idle(); chk("br_last", last_word, 16'hFF2B);
        send(GROUP_EXTENDED, 4'hC, 4'd0, 4'd0, 8'h00, 9'h000);
        wait_idle(); chk("ext_last", last_word, 16'h0C7F);
        send(GROUP_REG_MEMORY, 4'd3, 4'hA, 4'd2, 8'h00, 9'h000);
        wait_idle(); chk("rm_last", last_word, 16'hA9BF);
        send(GROUP_REG_MEMORY, 4'd8, 4'hA, 4'd2, 8'h00, 9'h000);
        chk("rm_op8_err", err, 1'b1); chk("rm_op8_nowr", mem_wr, 1'b0);
        cyc();
        send(GROUP_REG_MEMORY, 4'd3, 4'hA, 4'd4, 8'h00, 9'h000);
        chk("rm_rg4_err", err, 1'b1); chk("rm_rg4_nowr", mem_wr, 1'b0);
        cyc();

        // Stall in WR_LO, ignored addr_load, then reset in WR_HI
        load(16'h0200);
        ack_mode = 1;
        mem_ack  = 1'b0;
        send(GROUP_MATH_REG, 4'd3, 4'd2, 4'd5, 8'h00, 9'h000);
        for (int i = 0; i < 5; i++) begin
            addr_load = (i == 1);
            addr_in   = 16'h1234;
            cyc();
            addr_load = 1'b0;
            chk("stall_wr", mem_wr, 1'b1); chk("stall_addr", mem_addr, 16'h0200);
            chk("stall_data", mem_data, 8'h37); chk("stall_ready", in_ready, 1'b0);
        end
        ack_mode = 0; cyc();
        ack_mode = 1; cyc();
        chk("hi_addr", mem_addr, 16'h0201); chk("hi_wr", mem_wr, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_wr_drop", mem_wr, 1'b0); chk("rst_busy_drop", busy, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        ack_mode = 0;
        cyc();
        send(GROUP_EXTENDED, 4'd1, 4'd0, 4'd0, 8'h00, 9'h000);
        chk("post_rst_ptr", mem_addr, 16'h0000);
        wait_idle();

        // Pointer wrap-around
        load(16'hFFFF);
        send(GROUP_OTHERS, 4'd2, 4'd0, 4'd0, 8'h00, 9'h000);
        chk("wrap_lo", mem_addr, 16'hFFFF);
        cyc();
        chk("wrap_hi", mem_addr, 16'h0000);
        cyc();
        send(GROUP_RETURN, 4'd0, 4'd0, 4'd0, 8'h00, 9'h000);
        chk("wrap_ptr", mem_addr, 16'h0001);
        wait_idle();
        load(16'hFFFE);
        send(GROUP_STACK, 4'd7, 4'd3, 4'd0, 8'h00, 9'h000);
        wait_idle();
        send(GROUP_SINGLE_REG, 4'd1, 4'd9, 4'd0, 8'h00, 9'h000);
        chk("wrap_even_ptr", mem_addr, 16'h0000);
        wait_idle();

        // Randomized traffic
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom % 2);
            group     = 4'($urandom);
            operator  = 4'($urandom);
            rg1       = 4'($urandom);
            rg2       = 4'($urandom);
            val       = 8'($urandom);
            offset    = 9'($urandom);
            addr_load = ($urandom % 12 == 0);
            addr_in   = 16'($urandom);
            cyc();
        end
        in_valid = 1'b0; addr_load = 1'b0; ack_mode = 0;
        cyc();
        wait_idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Accepts decoded instruction fields (group, operator, registers, constant, branch offset) over a valid/ready handshake.
- Packs them into the 16-bit instruction word format that the CPU instruction decoder consumes.
- Writes the word little-endian into program memory over the 8-bit write bus, at an auto-incrementing address.
- Used by the bootstrap loader and the debug port to deposit programs; it is the exact inverse of the decoder.

Parameters:
- ADDR_W, 16, width of the program address pointer and of mem_addr.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  field set presented
- in_ready  out  1  encoder accepts a field set this cycle
- group  in  4  `GROUP_* code from cpu_data.v
- operator  in  4  operator code (`OP_*)
- rg1  in  4  first register field
- rg2  in  4  second register field
- val  in  8  constant (MATH_CONSTANT)
- offset  in  9  signed branch offset field (BRANCH_JUMPS)
- addr_load  in  1  load write pointer from addr_in
- addr_in  in  ADDR_W  new write pointer
- mem_addr  out  ADDR_W  byte write address
- mem_data  out  8  byte write data
- mem_wr  out  1  write request; held until acked
- mem_ack  in  1  write accepted; sampled on the edge while mem_wr=1
- err  out  1  one-cycle pulse: illegal field set rejected
- busy  out  1  state != IDLE
- last_word  out  16  last successfully encoded word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ptr=0; mem_wr=0; mem_addr=0; mem_data=0; err=0; last_word=0.
  - mem_wr drops immediately, including mid-write; the word in progress is abandoned.
- FSM has three states: IDLE, WR_LO, WR_HI.
- in_ready = (state==IDLE) && !addr_load.
- addr_load:
  - Honoured only in IDLE: ptr <= addr_in.
  - Ignored in WR_LO and WR_HI.
  - Has priority over in_valid in the same cycle, because in_ready=0.
- Encoding is combinational from the inputs (b=word bit):
  - MATH_CONSTANT: {val, rg1, operator}. Legal only if operator[0]==0 or operator[1:0]==2'b01.
  - BRANCH_JUMPS: {offset[8:0], operator, 3'b011}.
  - MATH_REG: {rg2, rg1, operator, 4'b0111}.
  - MATH_EREG: {3'b000, rg2[1:0], rg1[1:0], operator, 5'b01111}. Legal only if rg1[3:2]==0 and rg2[3:2]==0.
  - SINGLE_REG or STACK: {2'b00, rg1, operator, 6'b011111}.
  - REG_MEMORY: {rg2[1:0], rg1, operator[2:0], 7'b0111111}. Legal only if operator[3]==0 and rg2[3:2]==0.
  - EXTENDED: {4'h0, operator, 8'h7F}.
  - OTHERS or RETURN: {4'h0, operator, 8'hFF}.
  - Any other group code is illegal.
- Acceptance in IDLE (in_valid && in_ready):
  - Illegal: err=1 for exactly the next cycle; stay in IDLE; no write; ptr and last_word unchanged.
  - Legal: latch the word and last_word; go to WR_LO. Next cycle mem_wr=1, mem_addr=ptr, mem_data=word[7:0].
- WR_LO:
  - Outputs held stable until mem_ack.
  - On ack: go to WR_HI with mem_addr=ptr+1 (mod 2^ADDR_W) and mem_data=word[15:8].
- WR_HI:
  - On ack: ptr <= ptr+2 (mod 2^ADDR_W); mem_wr=0; return to IDLE.
  - Earliest next acceptance is the cycle after returning to IDLE.
- Latency and throughput:
  - Accept to first mem_wr: 1 cycle.
  - With mem_ack tied high, one word takes 3 cycles (accept, lo, hi).
- ptr has no alignment requirement. An odd pointer and wrap-around are both legal.
- err and busy are never asserted together.

Decomposition:
- Group and operator codes stay in the shared cpu_data.v include as `GROUP_*/`OP_* macros.
- Add format constants to cpu_data.v: low-bit tags 3'b011, 4'b0111, 5'b01111, 6'b011111, 7'b0111111, 8'h7F, 8'hFF. The decoder and encoder share these tags.
- One natural sub-module: instr_pack, purely combinational: fields -> {word[15:0], legal}. The FSM, pointer and bus handshake live in instr_encoder.

Test Plan:
- Load addr 0x0100; MATH_REG op=3 rg1=2 rg2=5 -> word 0x5237; bytes 0x37@0x0100, then 0x52@0x0101; ptr ends 0x0102; last_word=0x5237.
- MATH_CONSTANT op=2 rg1=1 val=0xAB -> 0xAB12. Then op=3 -> err pulses 1 cycle, no mem_wr, ptr unchanged.
- BRANCH_JUMPS op=5 offset=9'h1FE -> 0xFF2B. EXTENDED op=0xC -> 0x0C7F. Each is written as low byte then high byte.
- REG_MEMORY op=3 rg1=0xA rg2=2 -> 0xA9BF. The same with op=8 or rg2=4 -> err, no write.
- Hold mem_ack=0 for 5 cycles in WR_LO:
  - mem_wr, mem_addr and mem_data stay stable and in_ready=0.
  - addr_load pulsed during the wait is ignored.
  - Assert rst_n=0 in WR_HI -> mem_wr=0 immediately; after release, ptr=0 and state is IDLE.
- Load 0xFFFF; write any legal word -> bytes @0xFFFF, then @0x0000; ptr=0x0001. Load 0xFFFE -> final ptr=0x0000.
